gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Registered binary up/down counter that drives a Gray-coded copy of its value.
- Used as the encode side of Gray-code pointer exchange, for example as the write or read pointer of a clock-domain-crossing FIFO.
- The far domain decodes `gray_o` back to binary.
- `gray_o` is a flop output, so it is glitch-free and changes exactly one bit per count step.

Parameters:
- `DATA_WIDTH`, 4, counter and code width in bits (legal range 2 to 32).

Ports:
- `clk_i`  input  1  clock; all state updates on rising edge.
- `rst_ni`  input  1  synchronous active-low reset.
- `clear_i`  input  1  synchronous clear to zero.
- `load_i`  input  1  load counter from `load_data_i`.
- `load_data_i`  input  `DATA_WIDTH`  load value; binary unless the optional feature is enabled.
- `en_i`  input  1  count enable; one step per cycle.
- `dir_i`  input  1  count direction; 1 = up, 0 = down; sampled only when `en_i`=1.
- `bin_o`  output  `DATA_WIDTH`  registered binary count.
- `gray_o`  output  `DATA_WIDTH`  registered Gray code of the next-state binary value.
- `wrap_o`  output  1  one-cycle pulse on count wrap-around.

Behaviour:
- Reset (`rst_ni`=0 at a rising edge): `bin_o`=0, `gray_o`=0, `wrap_o`=0. Reset is synchronous and active-low; there is no asynchronous path.
- Priority, evaluated each rising edge: reset > `clear_i` > `load_i` > `en_i` > hold.
- `clear_i`=1: next bin = 0, next gray = 0, `wrap_o`=0.
- `load_i`=1:
  - next bin = `load_data_i`; next gray = `load_data_i` ^ (`load_data_i` >> 1); `wrap_o`=0.
  - `en_i` and `dir_i` are ignored that cycle.
- `en_i`=1, `dir_i`=1: next bin = bin + 1, modulo 2^`DATA_WIDTH`.
- `en_i`=1, `dir_i`=0: next bin = bin - 1, modulo 2^`DATA_WIDTH`.
- `en_i`=0 with no clear or load: all outputs hold; `wrap_o` goes to 0.
- Latency: one cycle from the controlling input edge to `bin_o`, `gray_o` and `wrap_o`. All three update on the same edge.
- Gray rule: `gray_o` = next_bin ^ (next_bin >> 1), computed from the next-state value and registered. It is never derived combinationally from `bin_o` at the output.
- Single-bit change: every enabled count step changes exactly one `gray_o` bit, including across wrap-around. Load and clear may change any number of bits.
- `wrap_o`:
  - Asserted for exactly one cycle on a counting step from all-ones to 0 (up) or from 0 to all-ones (down).
  - Never asserted by load, clear or reset, even if the loaded value equals the wrap target.
- Back-to-back direction changes are legal. Example: up then down returns to the original value with no `wrap_o` unless the wrap boundary is crossed.
- Reset mid-operation overrides every other input on that edge. Counting resumes from 0 on the first edge after `rst_ni` returns high.
- X-handling: control inputs are don't-care while `rst_ni`=0.

Optional Feature:
- Macro: `GRAY_COUNTER_LOAD_GRAY_EN`.
- When defined, `load_data_i` is interpreted as Gray code.
  - The block converts it to binary internally: MSB passes through, and each lower bit = the next-higher binary bit XOR the Gray bit.
  - next bin = converted value; next gray = `load_data_i` unchanged.
  - Load-to-output latency remains one cycle.
  - This lets a receive-side Gray pointer be reloaded directly.
- When undefined, `load_data_i` is binary as described above.
- No port changes in either case.

Test Plan:
- Reset: hold `rst_ni`=0 for 3 cycles with `en_i`=1 and `load_i`=1 -> `bin_o`=0, `gray_o`=0, `wrap_o`=0 on every cycle.
- Full up sweep, `DATA_WIDTH`=4: `en_i`=1, `dir_i`=1 for 17 cycles ->
  - `bin_o` runs 0..15 then 0;
  - `gray_o` sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0;
  - exactly one `gray_o` bit changes per step;
  - `wrap_o`=1 only on the 15->0 step.
- Down wrap: `load_i` with `load_data_i`=2 (binary build), then `dir_i`=0 for 3 steps -> `bin_o` 2,1,0,15; `gray_o`=8 at 15; `wrap_o` pulses once at 0->15.
- Priority: same cycle `clear_i`=1, `load_i`=1 (`load_data_i`=9), `en_i`=1 -> `bin_o`=0. Next cycle `load_i` only -> `bin_o`=9, `gray_o`=D, `wrap_o`=0. Then `en_i`=0 for 5 cycles -> outputs hold at 9 and D.
- Reset mid-count: count up to 7, drop `rst_ni` for 1 cycle with `en_i`=1 -> `bin_o`=0 next cycle, then 1,2,... after release.
- Optional macro defined: `load_data_i`=D (Gray) -> `bin_o`=9, `gray_o`=D. One up step -> `bin_o`=A, `gray_o`=F.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-coded copy and a one-cycle wrap pulse.
// Optional macro GRAY_COUNTER_LOAD_GRAY_EN: load_data_i is taken as Gray code instead of binary.
module gray_counter #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  en_i,
    input  logic                  dir_i,
    output logic [DATA_WIDTH-1:0] bin_o,
    output logic [DATA_WIDTH-1:0] gray_o,
    output logic                  wrap_o
);

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] load_bin;
    logic [DATA_WIDTH-1:0] load_gray;
    logic [DATA_WIDTH-1:0] next_bin;
    logic [DATA_WIDTH-1:0] next_gray;
    logic                  next_wrap;

    // Interpret the load word; Gray-to-binary is a prefix XOR done in log2 doubling steps
    always_comb begin
        load_bin  = load_data_i;
        load_gray = load_data_i;
`ifdef GRAY_COUNTER_LOAD_GRAY_EN
        for (int unsigned s = 1; s < DATA_WIDTH; s = s << 1) begin
            load_bin = load_bin ^ (load_bin >> s);
        end
`else
        load_gray = load_data_i ^ (load_data_i >> 1);
`endif
    end

    // Next-state selection: clear > load > count > hold
    always_comb begin
        next_bin  = bin_o;
        next_gray = gray_o;
        next_wrap = 1'b0;
        if (clear_i) begin
            next_bin  = '0;
            next_gray = '0;
        end else if (load_i) begin
            next_bin  = load_bin;
            next_gray = load_gray;
        end else if (en_i) begin
            if (dir_i) begin
                next_bin  = bin_o + ONE;
                next_wrap = (bin_o == ALL_ONES);
            end else begin
                next_bin  = bin_o - ONE;
                next_wrap = (bin_o == '0);
            end
            next_gray = next_bin ^ (next_bin >> 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bin_o  <= '0;
            gray_o <= '0;
            wrap_o <= 1'b0;
        end else begin
            bin_o  <= next_bin;
            gray_o <= next_gray;
            wrap_o <= next_wrap;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural reference model.
module tb_gray_counter;

    localparam int unsigned W = 4;
    localparam int unsigned MODN = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         load;
    logic [W-1:0] load_data;
    logic         en;
    logic         dir;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    gray_counter #(.DATA_WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .load_i     (load),
        .load_data_i(load_data),
        .en_i       (en),
        .dir_i      (dir),
        .bin_o      (bin),
        .gray_o     (gray),
        .wrap_o     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic         clear;
        logic         load;
        logic [W-1:0] data;
        logic         en;
        logic         dir;
        logic [W-1:0] exp_bin;
        logic [W-1:0] exp_gray;
        logic         exp_wrap;
    } vec_t;

    vec_t vecs[$];

    // Encode a binary value in whatever form the load port expects in this build
    function automatic logic [W-1:0] enc(input int unsigned b);
        logic [W-1:0] v;
        v = W'(b);
`ifdef GRAY_COUNTER_LOAD_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    // Reference decode of a Gray word: search for the binary value whose code matches
    function automatic int unsigned gray_to_bin(input logic [W-1:0] g);
        for (int unsigned b = 0; b < MODN; b++) begin
            if ((W'(b) ^ (W'(b) >> 1)) == g) return b;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] code_of(input int unsigned b);
        logic [W-1:0] v;
        v = W'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic add(input logic r, input logic c, input logic l, input int unsigned d,
                       input logic e, input logic dr, input int unsigned eb,
                       input int unsigned eg, input logic ew);
        vec_t v;
        v.rst_n = r; v.clear = c; v.load = l; v.data = W'(d);
        v.en = e; v.dir = dr; v.exp_bin = W'(eb); v.exp_gray = W'(eg); v.exp_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic r, input logic c, input logic l, input logic [W-1:0] d,
                         input logic e, input logic dr);
        @(negedge clk);
        rst_n = r; clear = c; load = l; load_data = d; en = e; dir = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int unsigned eb, input int unsigned eg,
                             input logic ew);
        check({name, " bin"}, 32'(bin), 32'(eb));
        check({name, " gray"}, 32'(gray), 32'(eg));
        check({name, " wrap"}, 32'(wrap), 32'(ew));
    endtask

    logic [W-1:0] gseq [16];
    logic [W-1:0] prev_gray;

    initial begin
        rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_data = '0; en = 1'b0; dir = 1'b0;
        gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

        // Reset held with load and enable active
        for (int i = 0; i < 3; i++) add(0, 0, 1, 5, 1, 1, 0, 0, 0);
        // Full up sweep through wrap
        for (int i = 1; i <= 16; i++)
            add(1, 0, 0, 0, 1, 1, i % 16, gseq[i % 16], i == 16);
        // Down wrap from a loaded 2
        add(1, 0, 1, enc(2), 1, 1, 2, 3, 0);
        add(1, 0, 0, 0, 1, 0, 1, 1, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 15, 8, 1);
        add(1, 0, 0, 0, 0, 0, 15, 8, 0);
        // Priority: clear over load over enable, then hold
        add(1, 1, 1, enc(9), 1, 1, 0, 0, 0);
        add(1, 0, 1, enc(9), 0, 0, 9, 4'hD, 0);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 3, 0, 1, 9, 4'hD, 0);
        // Load of a wrap target never pulses wrap; counting across it does
        add(1, 0, 1, enc(0), 1, 0, 0, 0, 0);
        add(1, 0, 1, enc(15), 1, 1, 15, 8, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 1);
        // Direction change without crossing the boundary
        add(1, 0, 1, enc(2), 0, 0, 2, 3, 0);
        add(1, 0, 0, 0, 1, 1, 3, 2, 0);
        add(1, 0, 0, 0, 1, 0, 2, 3, 0);
        // Reset mid-count: count to 7, reset with enable high, resume
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add(1, 0, 0, 0, 1, 1, i, gseq[i], 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 1, 1, 0);
        add(1, 0, 0, 0, 1, 1, 2, 3, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst_n, vecs[i].clear, vecs[i].load, vecs[i].data,
                  vecs[i].en, vecs[i].dir);
            check_out($sformatf("vec%0d", i), vecs[i].exp_bin, vecs[i].exp_gray,
                      vecs[i].exp_wrap);
        end

`ifdef GRAY_COUNTER_LOAD_GRAY_EN
        // Gray-coded reload: D decodes to 9, next up step gives A / F
        apply(1, 0, 1, 4'hD, 0, 0);
        check_out("gray_load", 9, 4'hD, 0);
        apply(1, 0, 0, 4'h0, 1, 1);
        check_out("gray_load_step", 4'hA, 4'hF, 0);
`endif

        // Randomized traffic against the reference model
        begin
            int unsigned m_bin;
            logic        m_wrap;
            logic        r, c, l, e, dr;
            logic [W-1:0] d;
            m_bin = 0;
            for (int i = 0; i < 600; i++) begin
                r  = (i == 0) ? 1'b0 : ($urandom_range(31) != 0);
                c  = ($urandom_range(15) == 0);
                l  = ($urandom_range(7) == 0);
                e  = ($urandom_range(3) != 0);
                dr = 1'($urandom);
                d  = W'($urandom);
                prev_gray = gray;
                m_wrap = 1'b0;
                if (!r || c) begin
                    m_bin = 0;
                end else if (l) begin
`ifdef GRAY_COUNTER_LOAD_GRAY_EN
                    m_bin = gray_to_bin(d);
`else
                    m_bin = d;
`endif
                end else if (e) begin
                    if (dr) begin
                        m_wrap = (m_bin == MODN - 1);
                        m_bin  = (m_bin + 1) % MODN;
                    end else begin
                        m_wrap = (m_bin == 0);
                        m_bin  = (m_bin + MODN - 1) % MODN;
                    end
                end
                apply(r, c, l, d, e, dr);
                check_out($sformatf("rand%0d", i), m_bin, code_of(m_bin), m_wrap);
                if (i > 0 && r && !c && !l && e)
                    check($sformatf("rand%0d onebit", i), 32'($countones(prev_gray ^ gray)), 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
